// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter-side signals of the UART transmit arbiter.
// Handshake: a requester raises req_valid with req_data and holds both until its req_ack pulse.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ack;
   logic                 tx_en;
   logic [7:0]           tx_data;
   logic [NUM_REQ-1:0]   grant;
   logic                 busy;
   logic [1:0]           state;

   modport master (
      output req_valid, req_data,
      input  req_ack, tx_en, tx_data, grant, busy, state
   );

   modport slave (
      input  req_valid, req_data,
      output req_ack, tx_en, tx_data, grant, busy, state
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between NUM_REQ requesters.
// Frame and gap timing are counted here because the transmitter gives no busy/done feedback.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 2,
   parameter int CLKS_PER_BIT = 10417,
   parameter int FRAME_BITS   = 10,
   parameter int GAP_BITS     = 1
) (
   input logic              clk,
   input logic              rst,
   uart_tx_arbiter_if.slave bus
);

   localparam int IDXW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int SEND_CYC = CLKS_PER_BIT * FRAME_BITS;
   localparam int GAP_CYC  = CLKS_PER_BIT * GAP_BITS;
   localparam int CW       = $clog2(SEND_CYC) + 1;
   localparam logic [CW-1:0] SEND_LAST = CW'(SEND_CYC - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_SEND = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt;
   logic [IDXW-1:0] ptr, sel, pick, idx;
   logic           pick_ok;
   logic           send_done, gap_done;
   int             idx_i;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDXW-1:0] i);
      onehot    = '0;
      onehot[i] = 1'b1;
   endfunction

   function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
      if (i == IDXW'(NUM_REQ - 1)) next_idx = '0;
      else                         next_idx = i + 1'b1;
   endfunction

   // First valid requester at or after the pointer, wrapping around.
   always_comb begin
      pick    = '0;
      pick_ok = 1'b0;
      idx_i   = 0;
      idx     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx_i = int'(ptr) + k;
         if (idx_i >= NUM_REQ) idx_i = idx_i - NUM_REQ;
         idx = IDXW'(idx_i);
         if (!pick_ok && bus.req_valid[idx]) begin
            pick    = idx;
            pick_ok = 1'b1;
         end
      end
   end

   assign send_done = (cnt == SEND_LAST);
   assign gap_done  = (cnt == GAP_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (pick_ok) state_nxt = S_LOAD;
         S_LOAD: state_nxt = S_SEND;
         S_SEND: if (send_done) state_nxt = (GAP_CYC == 0) ? S_IDLE : S_GAP;
         S_GAP:  if (gap_done) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         ptr         <= '0;
         sel         <= '0;
         bus.tx_en   <= 1'b0;
         bus.tx_data <= 8'h00;
         bus.grant   <= '0;
         bus.req_ack <= '0;
         bus.busy    <= 1'b0;
      end else begin
         bus.req_ack <= '0;

         // Each state's counter starts at zero on entry.
         if (state_nxt != state)                      cnt <= '0;
         else if (state == S_SEND || state == S_GAP)  cnt <= cnt + 1'b1;

         case (state)
            S_IDLE: begin
               if (pick_ok) begin
                  sel         <= pick;
                  bus.grant   <= onehot(pick);
                  bus.req_ack <= onehot(pick);
                  bus.tx_data <= bus.req_data[{pick, 3'b000} +: 8];
                  bus.busy    <= 1'b1;
               end
            end
            S_LOAD: bus.tx_en <= 1'b1;
            S_SEND: begin
               if (send_done) begin
                  bus.tx_en   <= 1'b0;
                  bus.tx_data <= 8'h00;
                  bus.grant   <= '0;
                  ptr         <= next_idx(sel);
                  if (GAP_CYC == 0) bus.busy <= 1'b0;
               end
            end
            S_GAP: if (gap_done) bus.busy <= 1'b0;
            default: ;
         endcase
      end
   end

   assign bus.state = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with CLKS_PER_BIT=4, FRAME_BITS=10, GAP_BITS=1.
module tb_uart_tx_arbiter;

   logic clk;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   uart_tx_arbiter_if #(.NUM_REQ(2)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ(2), .CLKS_PER_BIT(4), .FRAME_BITS(10), .GAP_BITS(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi, bad, g, w, seen;
      int ack_cyc[4];
      logic [1:0] exp_ack[4];
      logic [7:0] exp_dat[4];
      exp_ack = '{2'b01, 2'b10, 2'b01, 2'b10};
      exp_dat = '{8'hA5, 8'hFF, 8'hA5, 8'hFF};

      // Reset with stimulus toggling
      rst           = 1'b1;
      bus.req_valid = 2'b00;
      bus.req_data  = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         bus.req_valid = 2'(i + 1);
         bus.req_data  = 16'(16'h1357 * (i + 1));
         tick();
      end
      check("rst_tx_en",   32'(bus.tx_en),   0);
      check("rst_grant",   32'(bus.grant),   0);
      check("rst_busy",    32'(bus.busy),    0);
      check("rst_req_ack", 32'(bus.req_ack), 0);
      check("rst_tx_data", 32'(bus.tx_data), 32'h00);
      bus.req_valid = 2'b00;
      bus.req_data  = 16'h0000;
      rst = 1'b0;
      tick();
      tick();
      check("idle_state", 32'(bus.state), 0);
      check("idle_busy",  32'(bus.busy),  0);

      // Single request from requester 0, with data changed mid-frame
      bus.req_valid = 2'b01;
      bus.req_data  = 16'h00AA;
      tick();
      check("load_ack",     32'(bus.req_ack), 32'h1);
      check("load_grant",   32'(bus.grant),   32'h1);
      check("load_tx_data", 32'(bus.tx_data), 32'hAA);
      check("load_busy",    32'(bus.busy),    1);
      check("load_tx_en",   32'(bus.tx_en),   0);
      bus.req_valid = 2'b00;
      tick();
      check("send_tx_en", 32'(bus.tx_en),   1);
      check("send_ack",   32'(bus.req_ack), 0);
      hi  = 1;
      bad = 0;
      while (bus.tx_en === 1'b1 && hi < 100) begin
         if (hi == 10) bus.req_data[7:0] = 8'h00;
         if (bus.tx_data !== 8'hAA || bus.grant !== 2'b01 || bus.req_ack !== 2'b00) bad++;
         tick();
         if (bus.tx_en === 1'b1) hi++;
      end
      check("frame_len",      32'(hi),  40);
      check("frame_unstable", 32'(bad), 0);
      check("gap_grant",   32'(bus.grant),   0);
      check("gap_busy",    32'(bus.busy),    1);
      check("gap_tx_data", 32'(bus.tx_data), 32'h00);
      check("gap_state",   32'(bus.state),   3);

      // One-cycle request pulse during the gap must be ignored
      g = 0;
      while (bus.busy === 1'b1 && g < 20) begin
         g++;
         bus.req_valid = (g == 2) ? 2'b10 : 2'b00;
         tick();
      end
      bus.req_valid = 2'b00;
      check("gap_len",        32'(g),         4);
      check("post_gap_state", 32'(bus.state), 0);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.req_ack !== 2'b00 || bus.tx_en !== 1'b0 || bus.busy !== 1'b0) seen++;
      end
      check("withdrawn_no_frame", 32'(seen), 0);

      // Pointer now favours requester 1; then reset in the middle of its frame
      bus.req_data  = 16'hFFA5;
      bus.req_valid = 2'b11;
      w = 0;
      while (bus.req_ack === 2'b00 && w < 20) begin
         tick();
         w++;
      end
      check("fair_ack",     32'(bus.req_ack), 32'h2);
      check("fair_tx_data", 32'(bus.tx_data), 32'hFF);
      tick();
      check("fair_tx_en", 32'(bus.tx_en), 1);
      repeat (10) tick();
      rst = 1'b1;
      #1;
      check("midrst_tx_en",   32'(bus.tx_en),   0);
      check("midrst_grant",   32'(bus.grant),   0);
      check("midrst_busy",    32'(bus.busy),    0);
      check("midrst_tx_data", 32'(bus.tx_data), 32'h00);
      tick();
      tick();
      rst = 1'b0;

      // Both continuously valid: grants rotate from requester 0, 46-cycle period
      for (int f = 0; f < 4; f++) begin
         w = 0;
         while (bus.req_ack === 2'b00 && w < 200) begin
            tick();
            w++;
         end
         ack_cyc[f] = cyc;
         check($sformatf("rr_ack_%0d", f),  32'(bus.req_ack), 32'(exp_ack[f]));
         check($sformatf("rr_data_%0d", f), 32'(bus.tx_data), 32'(exp_dat[f]));
         if (f > 0) check($sformatf("rr_period_%0d", f), 32'(ack_cyc[f] - ack_cyc[f-1]), 46);
         tick();
         check($sformatf("rr_tx_en_%0d", f), 32'(bus.tx_en), 1);
      end
      bus.req_valid = 2'b00;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
